// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter update unit.
package pc_unit_pkg;

  // Control state: normal operation, or the second step of exception entry.
  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StExcJump = 1'b1
  } pc_state_e;

  // Exception cause codes.
  localparam logic [1:0] CAUSE_OPCODE   = 2'd0;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
  localparam logic [1:0] CAUSE_DIVZERO  = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN    = 2'd3;

  // Default exception vector base.
  localparam logic [31:0] EXC_BASE_DEFAULT = 32'h0000_00FC;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational NUM_SRC-way selector over a flattened source bus.
// Out-of-range selectors yield zero data and sel_valid low, never X.
module pc_src_mux #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_bus,
  output logic [DATA_W-1:0]         data,
  output logic                      sel_valid
);

  // Compare the selector against every legal index; no match leaves the defaults.
  always_comb begin
    data      = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        data      = src_bus[i*DATA_W +: DATA_W];
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_update_unit.sv
// Program-counter register with source selection and two-step exception entry:
// the first cycle saves the EPC and latches the cause, the second loads the
// cause-indexed vector. Optional feature: define PC_ALIGN_CHECK_EN to trap
// writes of word-misaligned targets as a CAUSE_ALIGN exception.
module pc_update_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_SRC   = 5,
  parameter int unsigned       SEL_W     = $clog2(NUM_SRC),
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] EXC_BASE  = DATA_W'(EXC_BASE_DEFAULT),
  parameter int unsigned       VEC_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_bus,
  input  logic                      pc_write,
  input  logic                      pc_write_cond,
  input  logic                      branch_taken,
  input  logic                      exc_req,
  input  logic [1:0]                exc_cause,
  output logic [DATA_W-1:0]         pc_out,
  output logic [DATA_W-1:0]         epc_out,
  output logic                      exc_busy,
  output logic                      sel_err
);

  pc_state_e         state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [1:0]        cause_q, cause_d;
  logic              sel_err_q, sel_err_d;

  logic [DATA_W-1:0] target;
  logic              target_valid;
  logic              we;
  logic [DATA_W-1:0] vector;

  pc_src_mux #(
    .DATA_W (DATA_W),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .sel      (src_sel),
    .src_bus  (src_bus),
    .data     (target),
    .sel_valid(target_valid)
  );

  assign we     = pc_write | (pc_write_cond & branch_taken);
  // Wrap-around on overflow is intended.
  assign vector = EXC_BASE + (DATA_W'(cause_q) << VEC_SHIFT);

  // Next-state logic: exception beats writes; EXC_JUMP ignores all requests.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    sel_err_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (exc_req) begin
          epc_d   = pc_q;
          cause_d = exc_cause;
          state_d = StExcJump;
        end else if (we) begin
          if (!target_valid) begin
            sel_err_d = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
          end else if (target[1:0] != 2'b00) begin
            epc_d   = pc_q;
            cause_d = CAUSE_ALIGN;
            state_d = StExcJump;
`endif
          end else begin
            pc_d = target;
          end
        end
      end
      StExcJump: begin
        pc_d    = vector;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      cause_q   <= CAUSE_OPCODE;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign pc_out   = pc_q;
  assign epc_out  = epc_q;
  assign exc_busy = (state_q == StExcJump);
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed, table-driven bench for pc_update_unit (default parameters).
// Expectations for the misaligned-target step follow PC_ALIGN_CHECK_EN.
module tb_pc_update_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_SRC = 5;
  localparam int unsigned SEL_W   = 3;

  // Fixed candidate sources.
  localparam logic [31:0] SRC0 = 32'h0000_0080;
  localparam logic [31:0] SRC1 = 32'h0000_0100;
  localparam logic [31:0] SRC2 = 32'h0000_0040;
  localparam logic [31:0] SRC3 = 32'h0000_0200;
  localparam logic [31:0] SRC4 = 32'h0000_0042;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] PC_AFTER_MIS   = 32'h0000_0080;
  localparam logic [31:0] EPC_AFTER_MIS  = 32'h0000_0080;
  localparam logic        BUSY_AFTER_MIS = 1'b1;
  localparam logic [31:0] PC_SETTLED     = 32'h0000_0108;
`else
  localparam logic [31:0] PC_AFTER_MIS   = 32'h0000_0042;
  localparam logic [31:0] EPC_AFTER_MIS  = 32'h0000_0200;
  localparam logic        BUSY_AFTER_MIS = 1'b0;
  localparam logic [31:0] PC_SETTLED     = 32'h0000_0042;
`endif

  logic                      clk;
  logic                      reset;
  logic [SEL_W-1:0]          src_sel;
  logic [NUM_SRC*DATA_W-1:0] src_bus;
  logic                      pc_write;
  logic                      pc_write_cond;
  logic                      branch_taken;
  logic                      exc_req;
  logic [1:0]                exc_cause;
  logic [DATA_W-1:0]         pc_out;
  logic [DATA_W-1:0]         epc_out;
  logic                      exc_busy;
  logic                      sel_err;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic        pw;
    logic        pwc;
    logic        bt;
    logic        exc;
    logic [1:0]  cause;
    logic [2:0]  sel;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic        exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  pc_update_unit #(
    .DATA_W   (DATA_W),
    .NUM_SRC  (NUM_SRC),
    .SEL_W    (SEL_W),
    .RESET_PC (32'h0000_0000),
    .EXC_BASE (32'h0000_00FC),
    .VEC_SHIFT(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_sel      (src_sel),
    .src_bus      (src_bus),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_taken (branch_taken),
    .exc_req      (exc_req),
    .exc_cause    (exc_cause),
    .pc_out       (pc_out),
    .epc_out      (epc_out),
    .exc_busy     (exc_busy),
    .sel_err      (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic pw, input logic pwc, input logic bt, input logic exc,
                     input logic [1:0] cause, input logic [2:0] sel,
                     input logic [31:0] exp_pc, input logic [31:0] exp_epc,
                     input logic exp_busy, input logic exp_err);
    vec_t v;
    v.pw = pw; v.pwc = pwc; v.bt = bt; v.exc = exc; v.cause = cause; v.sel = sel;
    v.exp_pc = exp_pc; v.exp_epc = exp_epc; v.exp_busy = exp_busy; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    pc_write = 1'b0; pc_write_cond = 1'b0; branch_taken = 1'b0;
    exc_req = 1'b0; exc_cause = 2'd0; src_sel = '0;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                           input logic busy, input logic err);
    check($sformatf("%s pc_out", tag), pc_out, pc);
    check($sformatf("%s epc_out", tag), epc_out, epc);
    check($sformatf("%s exc_busy", tag), 32'(exc_busy), 32'(busy));
    check($sformatf("%s sel_err", tag), 32'(sel_err), 32'(err));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    src_bus  = {SRC4, SRC3, SRC2, SRC1, SRC0};
    idle_inputs();

    //   pw  pwc bt  exc cause sel   exp_pc        exp_epc       busy err
    add(1, 0, 0, 0, 2'd0, 3'd2, 32'h040, 32'h000, 0, 0); // plain write
    add(0, 1, 0, 0, 2'd0, 3'd1, 32'h040, 32'h000, 0, 0); // cond write, not taken
    add(0, 1, 1, 0, 2'd0, 3'd1, 32'h100, 32'h000, 0, 0); // cond write, taken
    add(0, 0, 0, 0, 2'd0, 3'd3, 32'h100, 32'h000, 0, 0); // hold
    add(1, 0, 0, 0, 2'd0, 3'd3, 32'h200, 32'h000, 0, 0);
    add(1, 0, 0, 1, 2'd1, 3'd2, 32'h200, 32'h200, 1, 0); // exception beats write
    add(1, 0, 0, 0, 2'd0, 3'd2, 32'h100, 32'h200, 0, 0); // vector 0xFC+4, write ignored
    add(1, 0, 0, 0, 2'd0, 3'd6, 32'h100, 32'h200, 0, 1); // bad selector
    add(0, 0, 0, 0, 2'd0, 3'd0, 32'h100, 32'h200, 0, 0); // pulse ends
    add(1, 0, 0, 0, 2'd0, 3'd5, 32'h100, 32'h200, 0, 1); // first illegal index
    add(0, 1, 1, 0, 2'd0, 3'd7, 32'h100, 32'h200, 0, 1); // back-to-back errors
    add(0, 0, 0, 0, 2'd0, 3'd6, 32'h100, 32'h200, 0, 0); // no write, no error
    add(1, 0, 0, 0, 2'd0, 3'd0, 32'h080, 32'h200, 0, 0);
    add(1, 0, 0, 0, 2'd0, 3'd4, PC_AFTER_MIS, EPC_AFTER_MIS, BUSY_AFTER_MIS, 0);
    add(0, 0, 0, 0, 2'd0, 3'd0, PC_SETTLED, EPC_AFTER_MIS, 0, 0);
    add(0, 0, 0, 1, 2'd0, 3'd0, PC_SETTLED, PC_SETTLED, 1, 0); // exc held high
    add(0, 0, 0, 1, 2'd3, 3'd0, 32'h0FC, PC_SETTLED, 0, 0); // cause ignored in jump
    add(1, 0, 0, 1, 2'd2, 3'd6, 32'h0FC, 32'h0FC, 1, 0); // re-accepted; no sel_err
    add(0, 0, 0, 0, 2'd0, 3'd0, 32'h104, 32'h0FC, 0, 0);

    // Reset state.
    reset = 1'b1;
    #12;
    check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      pc_write      = vecs[i].pw;
      pc_write_cond = vecs[i].pwc;
      branch_taken  = vecs[i].bt;
      exc_req       = vecs[i].exc;
      exc_cause     = vecs[i].cause;
      src_sel       = vecs[i].sel;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_epc,
                vecs[i].exp_busy, vecs[i].exp_err);
    end

    // Reset asserted while in EXC_JUMP must abort the vector load.
    idle_inputs();
    exc_req   = 1'b1;
    exc_cause = 2'd2;
    @(posedge clk);
    #1;
    idle_inputs();
    check("abort pre busy", 32'(exc_busy), 32'd1);
    check("abort pre epc", epc_out, 32'h104);
    #2;
    reset = 1'b1;
    #1;
    check_all("abort async", 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("abort after", 32'h0, 32'h0, 1'b0, 1'b0);

    // Final write after recovery to confirm normal operation resumes.
    pc_write = 1'b1;
    src_sel  = 3'd1;
    @(posedge clk);
    #1;
    idle_inputs();
    check("resume pc", pc_out, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
